mem_access_unit: RTL and testbench

//  LC-3 memory access stage, directly downstream of the address adder. Captures the

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_access_unit_if                                            |
// | Brief    : Single-word memory request/ready bus between MAU and memory.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface mem_access_unit_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_access_unit                                               |
// | Brief    : LC-3 memory access stage: MAR/MDR plus req/ready transaction. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int DATA_W     = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   Adder,
    input  logic [DATA_W-1:0]   IR,
    input  logic [DATA_W-1:0]   BUS,
    input  logic                LD_MAR,
    input  logic                MARMUX_Ctrl,
    input  logic                LD_MDR,
    input  logic                MIO_EN,
    input  logic                R_W,
    output logic [DATA_W-1:0]   MAR,
    output logic [DATA_W-1:0]   MDR,
    output logic                R,
    output logic                Err,
    output logic                Busy,
    mem_access_unit_if.master   mem
);

    localparam int C_CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_LAST_WAIT = C_CNT_W'(WAIT_LIMIT - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_REQ  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  mar_q, mar_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic               abort_q, abort_d;
    logic [DATA_W-1:0]  w_mar_src;
    logic               unused_ir_hi;

    // Trap vectors live in IR[7:0]; the upper IR bits never reach MAR.
    assign w_mar_src    = MARMUX_Ctrl ? {{(DATA_W-8){1'b0}}, IR[7:0]} : Adder;
    assign unused_ir_hi = ^IR[DATA_W-1:8];

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        abort_d = abort_q;
        case (state_q)
            C_IDLE: begin
                if (LD_MAR) mar_d = w_mar_src;
                if (LD_MDR) mdr_d = BUS;
                if (MIO_EN) begin
                    state_d = C_REQ;
                    rw_d    = R_W;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end
            C_REQ: begin
                if (mem.mem_ready) begin
                    if (!rw_q) mdr_d = mem.mem_rdata;
                    state_d = C_DONE;
                end else begin
                    // Abort once the WAIT_LIMIT-th unanswered cycle has elapsed.
                    cnt_d = cnt_q + C_CNT_ONE;
                    if (cnt_q == C_LAST_WAIT) begin
                        abort_d = 1'b1;
                        state_d = C_DONE;
                    end
                end
            end
            C_DONE:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            abort_q <= abort_d;
        end
    end

    assign MAR           = mar_q;
    assign MDR           = mdr_q;
    assign R             = (state_q == C_DONE);
    assign Err           = (state_q == C_DONE) && abort_q;
    assign Busy          = (state_q != C_IDLE);
    assign mem.mem_req   = (state_q == C_REQ);
    assign mem.mem_we    = (state_q == C_REQ) && rw_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                            |
// | Brief    : Vector table, directed corner sequences and random vs model.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

    localparam int DATA_W     = 16;
    localparam int WAIT_LIMIT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] Adder = '0, IR = '0, BUS = '0, mem_rdata = '0;
    logic              LD_MAR = 1'b0, MARMUX_Ctrl = 1'b0, LD_MDR = 1'b0;
    logic              MIO_EN = 1'b0, R_W = 1'b0, mem_ready = 1'b0;
    logic [DATA_W-1:0] MAR, MDR;
    logic              R, Err, Busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(DATA_W)) mem_bus ();
    assign mem_bus.mem_rdata = mem_rdata;
    assign mem_bus.mem_ready = mem_ready;

    mem_access_unit #(.DATA_W(DATA_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .Adder(Adder), .IR(IR), .BUS(BUS),
        .LD_MAR(LD_MAR), .MARMUX_Ctrl(MARMUX_Ctrl), .LD_MDR(LD_MDR),
        .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR), .MDR(MDR), .R(R), .Err(Err),
        .Busy(Busy), .mem(mem_bus)
    );

    // Transaction-level reference: a request is "open" for some number of
    // cycles, then a single completion cycle follows.
    logic [DATA_W-1:0] m_mar = '0, m_mdr = '0;
    bit m_open = 0, m_write = 0, m_done = 0, m_err = 0;
    int m_waited = 0;

    task automatic model_edge();
        if (!rst_n) begin
            m_mar = '0; m_mdr = '0; m_open = 0; m_write = 0; m_done = 0; m_err = 0; m_waited = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_open) begin
            if (mem_ready) begin
                if (!m_write) m_mdr = mem_rdata;
                m_open = 0; m_done = 1; m_err = 0;
            end else begin
                m_waited = m_waited + 1;
                if (m_waited >= WAIT_LIMIT) begin
                    m_open = 0; m_done = 1; m_err = 1;
                end
            end
        end else begin
            if (LD_MAR) m_mar = MARMUX_Ctrl ? {8'h00, IR[7:0]} : Adder;
            if (LD_MDR) m_mdr = BUS;
            if (MIO_EN) begin
                m_open = 1; m_write = R_W; m_waited = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("model", {MAR, MDR, mem_bus.mem_addr, mem_bus.mem_wdata, R, Err, Busy,
                      mem_bus.mem_req, mem_bus.mem_we},
                     {m_mar, m_mdr, m_mar, m_mdr, m_done, m_done && m_err,
                      m_open || m_done, m_open, m_open && m_write});
    endtask

    task automatic quiet();
        rst_n = 1'b1; LD_MAR = 1'b0; MARMUX_Ctrl = 1'b0; LD_MDR = 1'b0;
        MIO_EN = 1'b0; R_W = 1'b0; mem_ready = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  ctl;   // rst_n, ld_mar, marmux, ld_mdr, mio_en, r_w, mem_ready
        logic [15:0] adder, ir, bus, rdata;
        logic [15:0] e_mar, e_mdr;
        logic [4:0]  e_flg; // R, Err, Busy, mem_req, mem_we
    } vec_t;

    vec_t vt[11];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n_req, n_r, n_start, pct;
        logic prev_req;

        vt[0]  = '{7'b0000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'b00000};
        vt[1]  = '{7'b1100000, 16'h3005, 16'h0000, 16'h0000, 16'h0000, 16'h3005, 16'h0000, 5'b00000};
        vt[2]  = '{7'b1000100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3005, 16'h0000, 5'b00110};
        vt[3]  = '{7'b1000001, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h3005, 16'hBEEF, 5'b10100};
        vt[4]  = '{7'b1000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3005, 16'hBEEF, 5'b00000};
        vt[5]  = '{7'b1110000, 16'h0000, 16'hF025, 16'h0000, 16'h0000, 16'h0025, 16'hBEEF, 5'b00000};
        vt[6]  = '{7'b1101110, 16'h1111, 16'h0000, 16'h5A5A, 16'h0000, 16'h1111, 16'h5A5A, 5'b00111};
        vt[7]  = '{7'b1111010, 16'h2222, 16'hF0AA, 16'h0000, 16'h0000, 16'h1111, 16'h5A5A, 5'b00111};
        vt[8]  = '{7'b1000001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h1111, 16'h5A5A, 5'b10100};
        vt[9]  = '{7'b1101100, 16'h3333, 16'h0000, 16'h7777, 16'h0000, 16'h1111, 16'h5A5A, 5'b00000};
        vt[10] = '{7'b1000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'h5A5A, 5'b00000};

        #1;
        for (int i = 0; i < 11; i++) begin
            {rst_n, LD_MAR, MARMUX_Ctrl, LD_MDR, MIO_EN, R_W, mem_ready} = vt[i].ctl;
            Adder = vt[i].adder; IR = vt[i].ir; BUS = vt[i].bus; mem_rdata = vt[i].rdata;
            tick();
            chk($sformatf("vec%0d", i),
                {MAR, MDR, mem_bus.mem_addr, R, Err, Busy, mem_bus.mem_req, mem_bus.mem_we},
                {vt[i].e_mar, vt[i].e_mdr, vt[i].e_mar, vt[i].e_flg});
        end

        // Reset held two cycles in the middle of a request.
        quiet(); Adder = 16'h3005; LD_MAR = 1'b1; BUS = 16'hABCD; LD_MDR = 1'b1; MIO_EN = 1'b1;
        tick();
        quiet(); tick();
        chk("rst_pre_req", mem_bus.mem_req, 1'b1);
        rst_n = 1'b0; tick(); tick();
        quiet(); mem_ready = 1'b1;
        chk("rst_req", mem_bus.mem_req, 1'b0);
        chk("rst_mar", MAR, 16'h0000);
        chk("rst_mdr", MDR, 16'h0000);
        n_r = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (R) n_r++;
        end
        chk("rst_no_r", n_r, 0);

        // Write that waits three cycles before mem_ready.
        quiet(); Adder = 16'h4000; LD_MAR = 1'b1; BUS = 16'h1234; LD_MDR = 1'b1; MIO_EN = 1'b1; R_W = 1'b1;
        tick();
        quiet();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_hold%0d", i),
                {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, R},
                {1'b1, 1'b1, 16'h4000, 16'h1234, 1'b0});
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        chk("wr_done", {R, Err, MDR}, {1'b1, 1'b0, 16'h1234});

        // Timeout: mem_ready never arrives on a read.
        quiet(); tick();
        BUS = 16'h1357; LD_MDR = 1'b1; MIO_EN = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        quiet(); mem_rdata = 16'hDEAD;
        n_req = 0;
        while (mem_bus.mem_req && n_req < 40) begin
            n_req++;
            tick();
        end
        chk("to_req_cycles", n_req, WAIT_LIMIT);
        chk("to_done", {R, Err, MDR}, {1'b1, 1'b1, 16'h1357});

        // Back-to-back reads with MIO_EN held high.
        quiet(); tick();
        MIO_EN = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0F0F;
        n_r = 0; n_start = 0; prev_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (R) n_r++;
            if (mem_bus.mem_req && !prev_req) n_start++;
            prev_req = mem_bus.mem_req;
        end
        chk("b2b_starts", n_start, 4);
        chk("b2b_r_pulses", n_r, 4);

        // Random traffic against the reference model.
        pct = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) pct = (i % 200 == 0) ? 0 : int'($urandom_range(5, 95));
            rst_n       = ($urandom_range(0, 99) >= 2);
            Adder       = 16'($urandom);
            IR          = 16'($urandom);
            BUS         = 16'($urandom);
            mem_rdata   = 16'($urandom);
            LD_MAR      = ($urandom_range(0, 99) < 30);
            MARMUX_Ctrl = ($urandom_range(0, 1) == 1);
            LD_MDR      = ($urandom_range(0, 99) < 30);
            MIO_EN      = ($urandom_range(0, 99) < 40);
            R_W         = ($urandom_range(0, 1) == 1);
            mem_ready   = ($urandom_range(0, 99) < pct);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
